// File: rtl/tt_pkg.sv
// Shared types for the truth-table sweeper: FSM state and table depth helper.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } tt_state_e;

   function automatic int tt_depth(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/tt_lut.sv
// Registered lookup: one bit of a 2^N-entry table selected by idx.
module tt_lut
   import tt_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [tt_depth(N)-1:0] tbl,
   input  logic [N-1:0]           idx,
   output logic                   q
);

   always_ff @(posedge clk) begin
      if (!rst_n) q <= 1'b0;
      else        q <= tbl[idx];
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Programmable N-input boolean function with direct lookup and full-table sweep.
// Optional minterm counter enabled by defining TT_ONES_COUNT_EN.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int N_IN = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_en,
   input  logic [tt_depth(N_IN)-1:0] tt_data,
   input  logic [N_IN-1:0]           in_vec,
   input  logic                      start,
   output logic                      f,
   output logic [N_IN-1:0]           sweep_idx,
   output logic                      sweep_f,
   output logic                      sweep_valid,
   output logic                      busy,
`ifdef TT_ONES_COUNT_EN
   output logic [N_IN:0]             ones_count,
`endif
   output logic                      done
);

   localparam int              D    = tt_depth(N_IN);
   localparam logic [N_IN-1:0] LAST = '1;

   tt_state_e       state, state_nxt;
   logic [D-1:0]    tbl_q, tbl_nxt;
   logic [N_IN-1:0] idx_nxt;
   logic            sw_q;

   always_comb begin
      state_nxt = state;
      tbl_nxt   = tbl_q;
      idx_nxt   = '0;
      unique case (state)
         IDLE: begin
            if (load_en) tbl_nxt = tt_data;
            if (start)   state_nxt = SWEEP;
         end
         SWEEP: begin
            if (sweep_idx == LAST) state_nxt = DONE;
            else idx_nxt = sweep_idx + N_IN'(1);
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         tbl_q     <= '0;
         sweep_idx <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         tbl_q     <= tbl_nxt;
         sweep_idx <= idx_nxt;
         busy      <= (state_nxt == SWEEP);
         done      <= (state_nxt == DONE);
      end
   end

   assign sweep_valid = busy;
   assign sweep_f     = sw_q & sweep_valid;

   tt_lut #(.N(N_IN)) u_direct (
      .clk   (clk),
      .rst_n (rst_n),
      .tbl   (tbl_q),
      .idx   (in_vec),
      .q     (f)
   );

   // Fed from next-state values so a same-edge load is seen by entry 0
   tt_lut #(.N(N_IN)) u_sweep (
      .clk   (clk),
      .rst_n (rst_n),
      .tbl   (tbl_nxt),
      .idx   (idx_nxt),
      .q     (sw_q)
   );

`ifdef TT_ONES_COUNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         ones_count <= '0;
      else if (state == IDLE && start)
         ones_count <= '0;
      else if (sweep_f)
         ones_count <= ones_count + (N_IN+1)'(1);
   end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized scoreboard bench for truth_table_sweeper (N_IN=4) plus an N_IN=1 case.
module tb_truth_table_sweeper;

   localparam int N = 4;
   localparam int D = 16;

   typedef struct {
      int idx;
      bit f;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_en = 1'b0;
   logic [D-1:0] tt_data = '0;
   logic [N-1:0] in_vec = '0;
   logic start = 1'b0;
   logic f, sweep_f, sweep_valid, busy, done;
   logic [N-1:0] sweep_idx;
   logic [N:0] ones_count;

   logic b_load = 1'b0;
   logic [1:0] b_tt = '0;
   logic [0:0] b_vec = '0;
   logic b_start = 1'b0;
   logic b_f, b_sf, b_valid, b_busy, b_done;
   logic [0:0] b_idx;
   logic [1:0] b_ones;

   int n_chk = 0;
   int n_err = 0;
   bit mon_on = 0;

   logic [D-1:0] tbl_m = '0;
   int busy_cnt = 0;
   int ones_m = 0;
   bit fq[$];
   ent_t sq[$];

   truth_table_sweeper #(.N_IN(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (load_en),
      .tt_data     (tt_data),
      .in_vec      (in_vec),
      .start       (start),
      .f           (f),
      .sweep_idx   (sweep_idx),
      .sweep_f     (sweep_f),
      .sweep_valid (sweep_valid),
      .busy        (busy),
`ifdef TT_ONES_COUNT_EN
      .ones_count  (ones_count),
`endif
      .done        (done)
   );

   truth_table_sweeper #(.N_IN(1)) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (b_load),
      .tt_data     (b_tt),
      .in_vec      (b_vec),
      .start       (b_start),
      .f           (b_f),
      .sweep_idx   (b_idx),
      .sweep_f     (b_sf),
      .sweep_valid (b_valid),
      .busy        (b_busy),
`ifdef TT_ONES_COUNT_EN
      .ones_count  (b_ones),
`endif
      .done        (b_done)
   );

`ifndef TT_ONES_COUNT_EN
   assign ones_count = '0;
   assign b_ones = '0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: behaviour stated in terms of accepted commands
   always @(posedge clk) begin
      if (!rst_n) begin
         fq.push_back(1'b0);
         tbl_m = '0;
         busy_cnt = 0;
         ones_m = 0;
         sq.delete();
      end else begin
         fq.push_back(tbl_m[in_vec]);
         if (busy_cnt == 0) begin
            if (load_en) tbl_m = tt_data;
            if (start) begin
               busy_cnt = D + 1;
               ones_m = 0;
               for (int k = 0; k < D; k++) begin
                  sq.push_back('{k, tbl_m[k]});
                  ones_m += int'(tbl_m[k]);
               end
            end
         end else begin
            busy_cnt--;
         end
      end
   end

   initial begin
      ent_t e;
      wait (mon_on);
      forever begin
         @(negedge clk);
         if (fq.size() > 0) chk("f", f, fq.pop_front());
         chk("busy", busy, busy_cnt >= 2);
         chk("valid", sweep_valid, busy_cnt >= 2);
         chk("done", done, busy_cnt == 1);
         if (sweep_valid) begin
            if (sq.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL sweep_extra: got idx %0d expected no entry", sweep_idx);
            end else begin
               e = sq.pop_front();
               chk("sweep_idx", sweep_idx, e.idx);
               chk("sweep_f", sweep_f, e.f);
            end
         end
         if (done) chk("sweep_len", sq.size(), 0);
`ifdef TT_ONES_COUNT_EN
         if (busy_cnt < 2) chk("ones_count", ones_count, ones_m);
`endif
      end
   end

   initial begin
      logic [31:0] r;
      cyc(1);
      mon_on = 1;
      cyc(1);
      chk("rst_f", f, 0);
      chk("rst_idx", sweep_idx, 0);
      chk("rst_sweep_f", sweep_f, 0);
      chk("rst_valid", sweep_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ones", ones_count, 0);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         r = $urandom;
         in_vec = r[3:0];
         cyc(1);
      end
      load_en = 1;
      tt_data = 16'hA5C3;
      cyc(1);
      load_en = 0;
      in_vec = 0;
      cyc(1);
      in_vec = 2;
      cyc(1);
      in_vec = 15;
      cyc(1);
      start = 1;
      cyc(1);
      start = 0;
      cyc(20);
      start = 1;
      cyc(1);
      start = 0;
      cyc(5);
      load_en = 1;
      tt_data = 16'hFFFF;
      start = 1;
      cyc(1);
      load_en = 0;
      start = 0;
      cyc(15);
      start = 1;
      cyc(1);
      start = 0;
      cyc(9);
      rst_n = 0;
      cyc(1);
      chk("abort_valid", sweep_valid, 0);
      chk("abort_busy", busy, 0);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         r = $urandom;
         in_vec = r[3:0];
         cyc(1);
      end
      r = $urandom;
      load_en = 1;
      start = 1;
      tt_data = r[15:0];
      cyc(1);
      load_en = 0;
      start = 0;
      cyc(18);
      start = 1;
      cyc(40);
      start = 0;
      cyc(20);
      for (int i = 0; i < 400; i++) begin
         r = $urandom;
         in_vec = r[3:0];
         tt_data = r[19:4];
         load_en = (r[23:22] == 2'b00);
         start = (r[26:24] == 3'b000);
         cyc(1);
      end
      load_en = 0;
      start = 0;
      cyc(20);
      chk("end_drain", sq.size(), 0);

      b_load = 1;
      b_tt = 2'b10;
      cyc(1);
      b_load = 0;
      b_start = 1;
      cyc(1);
      b_start = 0;
      chk("n1_valid0", b_valid, 1);
      chk("n1_idx0", b_idx, 0);
      chk("n1_f0", b_sf, 0);
      cyc(1);
      chk("n1_valid1", b_valid, 1);
      chk("n1_idx1", b_idx, 1);
      chk("n1_f1", b_sf, 1);
      chk("n1_nodone", b_done, 0);
      cyc(1);
      chk("n1_done", b_done, 1);
      chk("n1_valid_off", b_valid, 0);
      chk("n1_busy_off", b_busy, 0);
`ifdef TT_ONES_COUNT_EN
      chk("n1_ones", b_ones, 1);
`endif
      cyc(1);
      chk("n1_done_pulse", b_done, 0);
      b_vec = 1;
      cyc(1);
      chk("n1_direct", b_f, 1);
      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
